run_control: RTL
================

Name: run_control

Overview:
Run/halt/step sequencer for the microprocessor core. Turns the front-panel HALT switch, the active-low STEP pushbutton and an optional PC breakpoint into one registered stall output, H. H freezes the core. Halt takes effect only at instruction boundaries, marked by the core's INSTR_DONE pulse. Supports single-step and N-instruction burst step.

Parameters:
PC_W, 8, width of PC and BP_ADDR
CNT_W, 8, width of burst count, steps-left and retired counters

Ports:
CLK  in  1  system clock; all logic on posedge
RST_L  in  1  synchronous reset, active-low
HALT  in  1  level; 1 = halt mode requested
STEP_L  in  1  active-low step pushbutton (already synchronized)
BURST  in  CNT_W  instructions per step press; 0 treated as 1
INSTR_DONE  in  1  one-cycle pulse when the core retires an instruction
PC  in  PC_W  address of the instruction retiring this cycle
BP_EN  in  1  breakpoint enable
BP_ADDR  in  PC_W  breakpoint address
H  out  1  1 = core stalled
STATE  out  2  00 HALTED, 01 RUN, 10 STEP
STEPS_LEFT  out  CNT_W  remaining instructions in current step burst
BP_HIT  out  1  sticky: halted by breakpoint
RETIRED  out  CNT_W  count of INSTR_DONE pulses while H=0; wraps

Behaviour:
- Reset (RST_L=0 at posedge): STATE=HALTED, H=1, STEPS_LEFT=0, BP_HIT=0, RETIRED=0, step_prev=1. Reset mid-step aborts the burst.
- All outputs are registered. H=1 iff STATE=HALTED, so H updates on the same edge as STATE.
- Step edge: step_prev <= STEP_L every cycle. step_req = step_prev & ~STEP_L. One request per press; holding the button gives no repeat.
- HALTED:
  - If BP_HIT=0 and HALT=0: go RUN.
  - Else on step_req: clear BP_HIT. If HALT=0, go RUN. Otherwise go STEP with STEPS_LEFT = (BURST==0 ? 1 : BURST).
  - Otherwise stay HALTED. While BP_HIT=1, the core stays halted regardless of HALT until a step_req.
- RUN, on a cycle with INSTR_DONE=1, priority order:
  - (a) breakpoint match (BP_EN & PC==BP_ADDR): go HALTED, BP_HIT=1.
  - (b) HALT=1: go HALTED.
  - If HALT=1 and INSTR_DONE=0, stay RUN until the next boundary.
- STEP, on a cycle with INSTR_DONE=1, priority order:
  - (a) breakpoint match: go HALTED, BP_HIT=1, STEPS_LEFT=0.
  - (b) HALT=0: go RUN, STEPS_LEFT=0.
  - (c) STEPS_LEFT==1: go HALTED, STEPS_LEFT=0.
  - (d) otherwise STEPS_LEFT decrements.
  - With INSTR_DONE=0 and HALT=0: go RUN immediately.
  - step_req is ignored in STEP.
- RETIRED increments on INSTR_DONE while H=0. Wraps from 2^CNT_W-1 to 0. An INSTR_DONE while H=1 is a core protocol error and is not counted.
- Latency: step_req to H=0 is 1 cycle. The retiring INSTR_DONE to H=1 is 1 cycle.

Optional Feature:
RUN_CONTROL_BREAKPOINT_EN
- Defined: breakpoint compare and BP_HIT active as above.
- Undefined: BP_EN, BP_ADDR and PC are ignored. BP_HIT is tied 0. Priority rules (a) drop out; all other behaviour is unchanged.

Decomposition:
- Package run_control_pkg holds:
  - the state enum (HALTED=2'b00, RUN=2'b01, STEP=2'b10), with 2'b11 illegal and recovering to HALTED;
  - the default widths PC_W=8 and CNT_W=8.
- Sub-module step_edge_detect (CLK, RST_L, STEP_L, step_req) holds step_prev and the falling-edge logic.

Test Plan:
- Reset with HALT=1, STEP_L=1 -> H=1, STATE=00, RETIRED=0. Release HALT -> H=0 and STATE=01 on the next edge.
- RUN, assert HALT with INSTR_DONE low for 3 cycles, then pulse it -> H stays 0 for those 3 cycles and goes 1 the cycle after the pulse.
- HALTED, BURST=3, press STEP_L for 5 cycles, give 3 INSTR_DONE pulses -> STATE=10, STEPS_LEFT 3→2→1→0, H=1 after the third pulse, only one burst started. Repeat with BURST=0 -> exactly 1 instruction.
- BP_EN=1, BP_ADDR=8'h2A, RUN, INSTR_DONE with PC=8'h2A and HALT=0 -> H=1, BP_HIT=1, stays halted with HALT=0. Press STEP -> BP_HIT=0, STATE=RUN.
- STEP burst of 4, deassert HALT after 1 pulse -> STATE=RUN, STEPS_LEFT=0. Same with RST_L low mid-burst -> all reset values.
- 256 INSTR_DONE pulses in RUN with CNT_W=8 -> RETIRED wraps to 0. Pulses while H=1 are not counted.

Source files
------------

// File: rtl/run_control_pkg.sv
// Shared state encoding and default widths for the run/halt/step sequencer.
package run_control_pkg;

    typedef enum logic [1:0] {
        HALTED = 2'b00,
        RUN    = 2'b01,
        STEP   = 2'b10
    } state_t;

    localparam int DEF_PC_W  = 8;
    localparam int DEF_CNT_W = 8;

endpackage

// File: rtl/run_control_step_edge_detect.sv
// Falling-edge detector on the synchronized active-low STEP pushbutton.
// One request per press; holding the button produces no repeat.
module step_edge_detect (
    input  logic CLK,
    input  logic RST_L,
    input  logic STEP_L,
    output logic step_req
);

    logic step_prev;

    always_ff @(posedge CLK) begin
        if (!RST_L) begin
            step_prev <= 1'b1;
        end else begin
            step_prev <= STEP_L;
        end
    end

    assign step_req = step_prev & ~STEP_L;

endmodule

// File: rtl/run_control.sv
// Run/halt/step sequencer producing the registered core stall H; halts only at INSTR_DONE boundaries.
// Breakpoint compare and sticky BP_HIT exist only when RUN_CONTROL_BREAKPOINT_EN is defined.
module run_control
    import run_control_pkg::*;
#(
    parameter int PC_W  = DEF_PC_W,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             CLK,
    input  logic             RST_L,
    input  logic             HALT,
    input  logic             STEP_L,
    input  logic [CNT_W-1:0] BURST,
    input  logic             INSTR_DONE,
    input  logic [PC_W-1:0]  PC,
    input  logic             BP_EN,
    input  logic [PC_W-1:0]  BP_ADDR,
    output logic             H,
    output logic [1:0]       STATE,
    output logic [CNT_W-1:0] STEPS_LEFT,
    output logic             BP_HIT,
    output logic [CNT_W-1:0] RETIRED
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    state_t           state, state_n;
    logic [CNT_W-1:0] steps_left, steps_n;
    logic [CNT_W-1:0] retired;
    logic             bp_hit, bp_hit_n;
    logic             h;
    logic             step_req;
    logic             bp_match;

    step_edge_detect u_step_edge (
        .CLK      (CLK),
        .RST_L    (RST_L),
        .STEP_L   (STEP_L),
        .step_req (step_req)
    );

`ifdef RUN_CONTROL_BREAKPOINT_EN
    assign bp_match = BP_EN && (PC == BP_ADDR);
`else
    logic unused_bp;
    assign unused_bp = BP_EN ^ (^BP_ADDR) ^ (^PC);
    assign bp_match  = 1'b0;
`endif

    always_comb begin
        state_n  = state;
        steps_n  = steps_left;
        bp_hit_n = bp_hit;
        case (state)
            HALTED: begin
                if (!bp_hit && !HALT) begin
                    state_n = RUN;
                end else if (step_req) begin
                    bp_hit_n = 1'b0;
                    if (!HALT) begin
                        state_n = RUN;
                    end else begin
                        state_n = STEP;
                        steps_n = (BURST == '0) ? ONE : BURST;
                    end
                end
            end
            RUN: begin
                if (INSTR_DONE) begin
                    if (bp_match) begin
                        state_n  = HALTED;
                        bp_hit_n = 1'b1;
                    end else if (HALT) begin
                        state_n = HALTED;
                    end
                end
            end
            STEP: begin
                if (INSTR_DONE) begin
                    if (bp_match) begin
                        state_n  = HALTED;
                        bp_hit_n = 1'b1;
                        steps_n  = '0;
                    end else if (!HALT) begin
                        state_n = RUN;
                        steps_n = '0;
                    end else if (steps_left == ONE) begin
                        state_n = HALTED;
                        steps_n = '0;
                    end else begin
                        steps_n = steps_left - ONE;
                    end
                end else if (!HALT) begin
                    // Leaving halt mode mid-burst abandons the remaining count.
                    state_n = RUN;
                    steps_n = '0;
                end
            end
            default: begin
                state_n = HALTED;
                steps_n = '0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_L) begin
            state      <= HALTED;
            h          <= 1'b1;
            steps_left <= '0;
            bp_hit     <= 1'b0;
            retired    <= '0;
        end else begin
            state      <= state_n;
            h          <= (state_n == HALTED);
            steps_left <= steps_n;
            bp_hit     <= bp_hit_n;
            // A retirement while stalled is a core protocol error and is not counted.
            if (INSTR_DONE && !h) begin
                retired <= retired + ONE;
            end
        end
    end

    assign H          = h;
    assign STATE      = state;
    assign STEPS_LEFT = steps_left;
    assign BP_HIT     = bp_hit;
    assign RETIRED    = retired;

endmodule
